regfile_write_arbiter: RTL and testbench

//   Shares the single register-file write port between two writeback requesters
//   (A = ALU writeback, B = load/memory writeback) using valid/ready handshakes
//   and round-robin priority. Also runs a clear sequence that zeroes registers
//   1..NUM_REGS-1 through the same port. Sits between the execute/memory stages
//   and Register_File, and drives its reg_write_dest/reg_write_data/write_data_en.

---
 rtl/regfile_write_arbiter_if.sv | 13 +
 rtl/regfile_write_arbiter.sv | 119 +++++++++++
 tb/tb_regfile_write_arbiter.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/regfile_write_arbiter_if.sv
// rtl/regfile_write_arbiter_if.sv - valid/ready writeback request channel (one per requester)
interface regfile_write_arbiter_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic              valid;
  logic [ADDR_W-1:0] dest;
  logic [DATA_W-1:0] data;
  logic              ready;

  modport master (output valid, output dest, output data, input  ready);
  modport slave  (input  valid, input  dest, input  data, output ready);
endinterface

// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - round-robin arbiter for the register-file write port
// Two writeback requesters share one registered write port; a clear sweep zeroes x1..x(NUM_REGS-1).
module regfile_write_arbiter #(
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  regfile_write_arbiter_if.slave a_if,
  regfile_write_arbiter_if.slave b_if,
  input  logic                  clear_start,
  output logic                  busy,
  output logic                  clear_done,
  output logic [ADDR_W-1:0]     reg_write_dest,
  output logic [DATA_W-1:0]     reg_write_data,
  output logic                  write_data_en
);

  typedef enum logic {ARB, CLEAR} state_t;

  localparam logic [ADDR_W-1:0] LAST_REG  = ADDR_W'(NUM_REGS - 1);
  localparam logic [ADDR_W-1:0] FIRST_REG = ADDR_W'(1);

  state_t            state_q, state_d;
  logic              rr_q, rr_d;          // 0: A favoured, 1: B favoured
  logic [ADDR_W-1:0] count_q, count_d;
  logic [ADDR_W-1:0] dest_q, dest_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              en_q, en_d;
  logic              done_q, done_d;
  logic              grant_a, grant_b;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ARB;
      rr_q    <= 1'b0;
      count_q <= FIRST_REG;
      dest_q  <= '0;
      data_q  <= '0;
      en_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      count_q <= count_d;
      dest_q  <= dest_d;
      data_q  <= data_d;
      en_q    <= en_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    count_d = count_q;
    dest_d  = dest_q;
    data_d  = data_q;
    en_d    = 1'b0;
    done_d  = 1'b0;
    grant_a = 1'b0;
    grant_b = 1'b0;

    case (state_q)
      ARB: begin
        if (clear_start) begin
          state_d = CLEAR;
        end else if (a_if.valid && (!b_if.valid || !rr_q)) begin
          grant_a = 1'b1;
        end else if (b_if.valid) begin
          grant_b = 1'b1;
        end

        // x0 is hardwired zero: the handshake completes but nothing is written
        if (grant_a) begin
          rr_d = 1'b1;
          if (a_if.dest != '0) begin
            en_d   = 1'b1;
            dest_d = a_if.dest;
            data_d = a_if.data;
          end
        end else if (grant_b) begin
          rr_d = 1'b0;
          if (b_if.dest != '0) begin
            en_d   = 1'b1;
            dest_d = b_if.dest;
            data_d = b_if.data;
          end
        end
      end

      CLEAR: begin
        en_d   = 1'b1;
        dest_d = count_q;
        data_d = '0;
        if (count_q == LAST_REG) begin
          state_d = ARB;
          done_d  = 1'b1;
          count_d = FIRST_REG;
          rr_d    = 1'b0;
        end else begin
          count_d = count_q + FIRST_REG;
        end
      end

      default: state_d = ARB;
    endcase
  end

  assign a_if.ready     = grant_a && !rst;
  assign b_if.ready     = grant_b && !rst;
  assign busy           = (state_q == CLEAR);
  assign clear_done     = done_q;
  assign reg_write_dest = dest_q;
  assign reg_write_data = data_q;
  assign write_data_en  = en_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb/tb_regfile_write_arbiter.sv - directed vector bench for regfile_write_arbiter
module tb_regfile_write_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear_start;
  logic        busy;
  logic        clear_done;
  logic [4:0]  reg_write_dest;
  logic [31:0] reg_write_data;
  logic        write_data_en;

  regfile_write_arbiter_if #(.ADDR_W(5), .DATA_W(32)) a_if ();
  regfile_write_arbiter_if #(.ADDR_W(5), .DATA_W(32)) b_if ();

  regfile_write_arbiter #(.ADDR_W(5), .DATA_W(32), .NUM_REGS(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .a_if           (a_if.slave),
    .b_if           (b_if.slave),
    .clear_start    (clear_start),
    .busy           (busy),
    .clear_done     (clear_done),
    .reg_write_dest (reg_write_dest),
    .reg_write_data (reg_write_data),
    .write_data_en  (write_data_en)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        av;
    logic [4:0]  ad;
    logic [31:0] adat;
    logic        bv;
    logic [4:0]  bd;
    logic [31:0] bdat;
    logic        ear;
    logic        ebr;
    logic        een;
    logic [4:0]  edest;
    logic [31:0] edata;
  } vec_t;

  vec_t vecs [12];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic av, input logic [4:0] ad, input logic [31:0] adat,
                       input logic bv, input logic [4:0] bd, input logic [31:0] bdat);
    a_if.valid = av; a_if.dest = ad; a_if.data = adat;
    b_if.valid = bv; b_if.dest = bd; b_if.data = bdat;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int writes;
    int dones;

    vecs[0]  = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,    1'b0, 1'b0, 1'b0, 5'd0,  32'h0};
    vecs[1]  = '{1'b1, 5'd3,  32'hDEAD_BEEF, 1'b0, 5'd0,  32'h0,    1'b1, 1'b0, 1'b1, 5'd3,  32'hDEAD_BEEF};
    vecs[2]  = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,    1'b0, 1'b0, 1'b0, 5'd3,  32'hDEAD_BEEF};
    vecs[3]  = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd7,  32'h77,   1'b0, 1'b1, 1'b1, 5'd7,  32'h77};
    vecs[4]  = '{1'b1, 5'd4,  32'h4444,      1'b1, 5'd5,  32'h5555, 1'b1, 1'b0, 1'b1, 5'd4,  32'h4444};
    vecs[5]  = '{1'b1, 5'd4,  32'h4444,      1'b1, 5'd5,  32'h5555, 1'b0, 1'b1, 1'b1, 5'd5,  32'h5555};
    vecs[6]  = '{1'b1, 5'd4,  32'h4444,      1'b1, 5'd5,  32'h5555, 1'b1, 1'b0, 1'b1, 5'd4,  32'h4444};
    vecs[7]  = '{1'b1, 5'd4,  32'h4444,      1'b1, 5'd5,  32'h5555, 1'b0, 1'b1, 1'b1, 5'd5,  32'h5555};
    vecs[8]  = '{1'b1, 5'd0,  32'h1234,      1'b0, 5'd0,  32'h0,    1'b1, 1'b0, 1'b0, 5'd5,  32'h5555};
    vecs[9]  = '{1'b1, 5'd9,  32'h99,        1'b0, 5'd0,  32'h0,    1'b1, 1'b0, 1'b1, 5'd9,  32'h99};
    vecs[10] = '{1'b1, 5'd10, 32'hAA,        1'b1, 5'd11, 32'hBB,   1'b0, 1'b1, 1'b1, 5'd11, 32'hBB};
    vecs[11] = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd0,  32'h0,    1'b0, 1'b1, 1'b0, 5'd11, 32'hBB};

    // reset state, with a request pending that must not be acknowledged
    rst = 1'b1;
    clear_start = 1'b0;
    drive(1'b1, 5'd6, 32'h66, 1'b1, 5'd7, 32'h77);
    #2;
    check("rst_a_ready", {31'b0, a_if.ready}, 32'd0);
    check("rst_b_ready", {31'b0, b_if.ready}, 32'd0);
    check("rst_en", {31'b0, write_data_en}, 32'd0);
    check("rst_dest", {27'b0, reg_write_dest}, 32'd0);
    check("rst_data", reg_write_data, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, clear_done}, 32'd0);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    tick();
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].av, vecs[i].ad, vecs[i].adat, vecs[i].bv, vecs[i].bd, vecs[i].bdat);
      #1;
      check($sformatf("v%0d_a_ready", i), {31'b0, a_if.ready}, {31'b0, vecs[i].ear});
      check($sformatf("v%0d_b_ready", i), {31'b0, b_if.ready}, {31'b0, vecs[i].ebr});
      tick();
      check($sformatf("v%0d_en", i), {31'b0, write_data_en}, {31'b0, vecs[i].een});
      check($sformatf("v%0d_dest", i), {27'b0, reg_write_dest}, {27'b0, vecs[i].edest});
      check($sformatf("v%0d_data", i), reg_write_data, vecs[i].edata);
    end
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    tick();

    // clear sweep with A pending; A waits until the sweep completes
    drive(1'b1, 5'd12, 32'hC0DE_0012, 1'b0, 5'd0, 32'h0);
    clear_start = 1'b1;
    #1;
    check("clr_start_a_ready", {31'b0, a_if.ready}, 32'd0);
    tick();
    clear_start = 1'b0;
    check("clr_busy_first", {31'b0, busy}, 32'd1);
    check("clr_en_first", {31'b0, write_data_en}, 32'd0);
    for (int k = 1; k <= 31; k++) begin
      #1;
      check($sformatf("clr%0d_a_stall", k), {31'b0, a_if.ready}, 32'd0);
      tick();
      check($sformatf("clr%0d_en", k), {31'b0, write_data_en}, 32'd1);
      check($sformatf("clr%0d_dest", k), {27'b0, reg_write_dest}, k);
      check($sformatf("clr%0d_data", k), reg_write_data, 32'd0);
      check($sformatf("clr%0d_busy", k), {31'b0, busy}, (k < 31) ? 32'd1 : 32'd0);
      check($sformatf("clr%0d_done", k), {31'b0, clear_done}, (k == 31) ? 32'd1 : 32'd0);
    end
    #1;
    check("post_clr_a_ready", {31'b0, a_if.ready}, 32'd1);
    tick();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    check("post_clr_en", {31'b0, write_data_en}, 32'd1);
    check("post_clr_dest", {27'b0, reg_write_dest}, 32'd12);
    check("post_clr_data", reg_write_data, 32'hC0DE_0012);
    check("post_clr_done", {31'b0, clear_done}, 32'd0);
    tick();

    // second clear_start pulse during the sweep must not extend or restart it
    clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    writes = 0;
    dones  = 0;
    for (int c = 0; c < 40; c++) begin
      clear_start = (c == 6);
      tick();
      if (write_data_en) writes++;
      if (clear_done) dones++;
    end
    clear_start = 1'b0;
    check("reclr_writes", writes, 32'd31);
    check("reclr_dones", dones, 32'd1);
    check("reclr_busy", {31'b0, busy}, 32'd0);

    // asynchronous reset in the middle of a sweep
    clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    for (int k = 1; k <= 9; k++) tick();
    check("mid_dest9", {27'b0, reg_write_dest}, 32'd9);
    rst = 1'b1;
    #1;
    check("mid_rst_en", {31'b0, write_data_en}, 32'd0);
    check("mid_rst_busy", {31'b0, busy}, 32'd0);
    check("mid_rst_done", {31'b0, clear_done}, 32'd0);
    check("mid_rst_dest", {27'b0, reg_write_dest}, 32'd0);
    tick();
    rst = 1'b0;
    dones = 0;
    writes = 0;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (write_data_en) writes++;
      if (clear_done || busy) dones++;
    end
    check("after_rst_writes", writes, 32'd0);
    check("after_rst_quiet", dones, 32'd0);
    drive(1'b1, 5'd13, 32'h1313, 1'b1, 5'd14, 32'h1414);
    #1;
    check("after_rst_a_ready", {31'b0, a_if.ready}, 32'd1);
    check("after_rst_b_ready", {31'b0, b_if.ready}, 32'd0);
    tick();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    check("after_rst_en", {31'b0, write_data_en}, 32'd1);
    check("after_rst_dest", {27'b0, reg_write_dest}, 32'd13);
    check("after_rst_data", reg_write_data, 32'h1313);
    tick();
    check("after_rst_en_off", {31'b0, write_data_en}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
